modport_game: RTL and testbench

Up/down counter game engine that moves a SIZE-bit counter in one of four modes and scores a win when the counter reaches all-ones and a loss when it reaches zero. Win and loss tallies are accumulated, and the block declares game over when either tally saturates. It sits behind the `game_io` interface as the single implementation of the counter, win_lose, count_signal, game_state and cont roles.

---
 rtl/modport_game.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_modport_game.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/modport_game.sv
// modport_game: SIZE-bit up/down counter game that scores wins at all-ones and losses at zero.
// Optional macro MODPORT_GAME_AUTOCLR_EN: clear all game state one cycle after GAMEOVER.

module modport_game_cont (
    input  logic clk,
    input  logic rst_n,
    input  logic gameover,
    output logic run_cnt,
    output logic run_score,
    output logic clr_reset,
    output logic hold
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // The counter may move on the edge that fills the second stage, so play starts
    // on the second edge after release; scoring waits for the fully settled stage.
    assign run_cnt   = sync_q[0];
    assign run_score = sync_q[1];

`ifdef MODPORT_GAME_AUTOCLR_EN
    assign clr_reset = gameover;
    assign hold      = 1'b0;
`else
    assign clr_reset = 1'b0;
    assign hold      = gameover;
`endif
endmodule

module modport_game_counter #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [1:0]      control,
    input  logic [SIZE-1:0] init_l,
    input  logic            init_c,
    output logic [SIZE-1:0] count,
    output logic [SIZE-1:0] direction,
    output logic            stepped
);
    logic [SIZE-1:0] count_q, count_d;
    logic [SIZE-1:0] dir_q, dir_d;
    logic            stepped_q, stepped_d;
    logic [SIZE-1:0] step;

    always_comb begin
        unique case (control)
            2'b00:   step = SIZE'(1);
            2'b01:   step = SIZE'(2);
            2'b10:   step = '1;
            default: step = ~SIZE'(1);
        endcase
    end

    always_comb begin
        count_d   = count_q;
        dir_d     = dir_q;
        stepped_d = stepped_q;
        if (clr) begin
            count_d   = '0;
            dir_d     = '0;
            stepped_d = 1'b0;
        end else if (en) begin
            if (init_c) begin
                count_d   = init_l;
                dir_d     = '0;
                stepped_d = 1'b0;
            end else begin
                count_d   = count_q + step;
                dir_d     = step;
                stepped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            dir_q     <= '0;
            stepped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            stepped_q <= stepped_d;
        end
    end

    assign count     = count_q;
    assign direction = dir_q;
    assign stepped   = stepped_q;
endmodule

module modport_game_win_lose #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic            stepped,
    input  logic [SIZE-1:0] count,
    output logic            winner,
    output logic            loser
);
    logic winner_q, winner_d;
    logic loser_q, loser_d;

    // Only a real count step can score, so loads and reset never pulse.
    always_comb begin
        winner_d = winner_q;
        loser_d  = loser_q;
        if (clr) begin
            winner_d = 1'b0;
            loser_d  = 1'b0;
        end else if (en) begin
            winner_d = stepped && (count == '1);
            loser_d  = stepped && (count == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_q <= 1'b0;
            loser_q  <= 1'b0;
        end else begin
            winner_q <= winner_d;
            loser_q  <= loser_d;
        end
    end

    assign winner = winner_q;
    assign loser  = loser_q;
endmodule

module modport_game_count_signal #(
    parameter int MAX_SCORE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 winner,
    input  logic                 loser,
    output logic [MAX_SCORE-1:0] w_count,
    output logic [MAX_SCORE-1:0] l_count
);
    logic [MAX_SCORE-1:0] w_q, w_d;
    logic [MAX_SCORE-1:0] l_q, l_d;

    always_comb begin
        w_d = w_q;
        l_d = l_q;
        if (clr) begin
            w_d = '0;
            l_d = '0;
        end else if (en) begin
            if (winner && (w_q != '1)) begin
                w_d = w_q + MAX_SCORE'(1);
            end
            if (loser && (l_q != '1)) begin
                l_d = l_q + MAX_SCORE'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
            l_q <= '0;
        end else begin
            w_q <= w_d;
            l_q <= l_d;
        end
    end

    assign w_count = w_q;
    assign l_count = l_q;
endmodule

module modport_game_state #(
    parameter int MAX_SCORE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [MAX_SCORE-1:0] w_count,
    input  logic [MAX_SCORE-1:0] l_count,
    output logic                 gameover,
    output logic [1:0]           who
);
    logic       gameover_q, gameover_d;
    logic [1:0] who_q, who_d;

    // Saturated tallies stay put while frozen, so this holds GAMEOVER without extra state.
    always_comb begin
        gameover_d = 1'b0;
        who_d      = 2'b00;
        if (!clr) begin
            if (w_count == '1) begin
                gameover_d = 1'b1;
                who_d      = 2'b01;
            end else if (l_count == '1) begin
                gameover_d = 1'b1;
                who_d      = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gameover_q <= 1'b0;
            who_q      <= 2'b00;
        end else begin
            gameover_q <= gameover_d;
            who_q      <= who_d;
        end
    end

    assign gameover = gameover_q;
    assign who      = who_q;
endmodule

module modport_game #(
    parameter int SIZE      = 4,
    parameter int MAX_SCORE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           control,
    input  logic [SIZE-1:0]      INIT_l,
    input  logic                 INIT_c,
    output logic [SIZE-1:0]      count,
    output logic [SIZE-1:0]      direction,
    output logic                 WINNER,
    output logic                 LOSER,
    output logic [MAX_SCORE-1:0] w_count,
    output logic [MAX_SCORE-1:0] l_count,
    output logic                 GAMEOVER,
    output logic [1:0]           WHO
);
    logic run_cnt;
    logic run_score;
    logic clr_reset;
    logic hold;
    logic stepped;

    modport_game_cont u_cont (
        .clk       (clk),
        .rst_n     (reset),
        .gameover  (GAMEOVER),
        .run_cnt   (run_cnt),
        .run_score (run_score),
        .clr_reset (clr_reset),
        .hold      (hold)
    );

    modport_game_counter #(.SIZE(SIZE)) u_counter (
        .clk       (clk),
        .rst_n     (reset),
        .clr       (clr_reset),
        .en        (run_cnt && !hold),
        .control   (control),
        .init_l    (INIT_l),
        .init_c    (INIT_c),
        .count     (count),
        .direction (direction),
        .stepped   (stepped)
    );

    modport_game_win_lose #(.SIZE(SIZE)) u_win_lose (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (clr_reset),
        .en      (!hold),
        .stepped (stepped),
        .count   (count),
        .winner  (WINNER),
        .loser   (LOSER)
    );

    modport_game_count_signal #(.MAX_SCORE(MAX_SCORE)) u_count_signal (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (clr_reset),
        .en      (run_score && !hold),
        .winner  (WINNER),
        .loser   (LOSER),
        .w_count (w_count),
        .l_count (l_count)
    );

    modport_game_state #(.MAX_SCORE(MAX_SCORE)) u_game_state (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (clr_reset),
        .w_count  (w_count),
        .l_count  (l_count),
        .gameover (GAMEOVER),
        .who      (WHO)
    );
endmodule

// File: tb/tb_modport_game.sv
// Self-checking bench for modport_game: directed vector table, corner sequences, random play vs model.
module tb_modport_game;
    localparam int CMAX = 15;
    localparam int SMAX = 15;
`ifdef MODPORT_GAME_AUTOCLR_EN
    localparam bit AUTOCLR = 1'b1;
`else
    localparam bit AUTOCLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] control = 2'b00;
    logic [3:0] INIT_l = 4'd0;
    logic       INIT_c = 1'b0;
    logic [3:0] count, direction, w_count, l_count;
    logic       WINNER, LOSER, GAMEOVER;
    logic [1:0] WHO;
    logic [20:0] dut_vec;

    int vectors = 0;
    int miscompares = 0;

    modport_game dut (
        .clk(clk), .reset(reset), .control(control), .INIT_l(INIT_l), .INIT_c(INIT_c),
        .count(count), .direction(direction), .WINNER(WINNER), .LOSER(LOSER),
        .w_count(w_count), .l_count(l_count), .GAMEOVER(GAMEOVER), .WHO(WHO)
    );

    always #5 clk = ~clk;

    assign dut_vec = {count, direction, WINNER, LOSER, w_count, l_count, GAMEOVER, WHO};

    typedef struct {
        logic [1:0]  ctrl;
        logic [3:0]  il;
        logic        ic;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model: game values kept as plain integers.
    int m_count, m_dir, m_w, m_l, m_who, m_edges;
    bit m_stepped, m_win, m_lose, m_go;

    function automatic logic [20:0] pack(input int cnt, input int dir, input int win, input int lose,
                                         input int w, input int l, input int go, input int who);
        return {4'(cnt), 4'(dir), 1'(win), 1'(lose), 4'(w), 4'(l), 1'(go), 2'(who)};
    endfunction

    function automatic vec_t mk(input int c, input int il, input int ic, input int cnt, input int dir,
                                input int win, input int lose, input int w, input int l,
                                input int go, input int who);
        vec_t v;
        v.ctrl = 2'(c);
        v.il   = 4'(il);
        v.ic   = 1'(ic);
        v.exp  = pack(cnt, dir, win, lose, w, l, go, who);
        return v;
    endfunction

    function automatic int delta_of(input logic [1:0] c);
        case (c)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return -1;
            default: return -2;
        endcase
    endfunction

    function automatic logic [20:0] model_vec();
        return pack(m_count, m_dir, int'(m_win), int'(m_lose), m_w, m_l, int'(m_go), m_who);
    endfunction

    task automatic model_reset();
        m_count = 0; m_dir = 0; m_w = 0; m_l = 0; m_who = 0; m_edges = 0;
        m_stepped = 0; m_win = 0; m_lose = 0; m_go = 0;
    endtask

    task automatic model_edge(input logic [1:0] c, input logic [3:0] il, input logic ic);
        int n_count = m_count, n_dir = m_dir, n_w = m_w, n_l = m_l, n_who = m_who;
        bit n_stepped = m_stepped, n_win = m_win, n_lose = m_lose, n_go = m_go;
        if (m_go && AUTOCLR) begin
            n_count = 0; n_dir = 0; n_w = 0; n_l = 0; n_who = 0;
            n_stepped = 0; n_win = 0; n_lose = 0; n_go = 0;
        end else if (!m_go) begin
            n_win  = m_stepped && (m_count == CMAX);
            n_lose = m_stepped && (m_count == 0);
            if (m_win && m_w < SMAX) n_w = m_w + 1;
            if (m_lose && m_l < SMAX) n_l = m_l + 1;
            n_go  = (m_w == SMAX) || (m_l == SMAX);
            n_who = (m_w == SMAX) ? 1 : ((m_l == SMAX) ? 2 : 0);
            if (m_edges >= 1) begin
                if (ic) begin
                    n_count = int'(il); n_dir = 0; n_stepped = 0;
                end else begin
                    n_count = (m_count + delta_of(c) + 16) % 16;
                    n_dir = (delta_of(c) + 16) % 16;
                    n_stepped = 1;
                end
            end
        end
        m_edges++;
        m_count = n_count; m_dir = n_dir; m_w = n_w; m_l = n_l; m_who = n_who;
        m_stepped = n_stepped; m_win = n_win; m_lose = n_lose; m_go = n_go;
    endtask

    task automatic check(input string name, input logic [20:0] exp);
        vectors++;
        if (dut_vec !== exp) begin
            miscompares++;
            $display("FAIL %s: {count,dir,WIN,LOSE,w,l,GO,WHO} got %b_%b_%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b_%b_%b",
                     name, dut_vec[20:17], dut_vec[16:13], dut_vec[12], dut_vec[11], dut_vec[10:7],
                     dut_vec[6:3], dut_vec[2], dut_vec[1:0], exp[20:17], exp[16:13], exp[12], exp[11],
                     exp[10:7], exp[6:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic apply(input logic [1:0] c, input logic [3:0] il, input logic ic);
        control = c; INIT_l = il; INIT_c = ic;
        @(posedge clk);
        model_edge(c, il, ic);
        #1;
    endtask

    task automatic do_reset(input string name);
        control = 2'b00; INIT_c = 1'b0; INIT_l = 4'd0;
        reset = 1'b0;
        #1;
        check({name, "_async"}, 21'd0);
        model_reset();
        @(posedge clk);
        #1;
        check({name, "_held"}, 21'd0);
        reset = 1'b1;
    endtask

    initial begin
        // Directed table after a clean reset release.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 15; i++) tbl.push_back(mk(0, 0, 0, i, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 1, 2, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 14, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 15, 15, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 0, 15, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 15, 15, 0, 1, 2, 1, 0, 0));
        tbl.push_back(mk(0, 7, 1, 7, 0, 1, 0, 2, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8, 1, 0, 0, 3, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 3, 2, 0, 0));

        do_reset("reset0");
        foreach (tbl[i]) begin
            apply(tbl[i].ctrl, tbl[i].il, tbl[i].ic);
            check($sformatf("table%0d", i), tbl[i].exp);
        end

        // Reset pulsed mid-game at count 7, w_count 3.
        for (int i = 0; i < 3; i++) begin
            apply(2'd1, 4'd0, 1'b0);
            check($sformatf("plus2_%0d", i), model_vec());
        end
        check("pre_reset", pack(7, 2, 0, 0, 3, 2, 0, 0));
        #2;
        do_reset("midreset");
        apply(2'd0, 4'd0, 1'b0);
        check("post_release_edge1", pack(0, 0, 0, 0, 0, 0, 0, 0));
        apply(2'd0, 4'd0, 1'b0);
        check("post_release_edge2", pack(1, 1, 0, 0, 0, 0, 0, 0));

        // Fifteen wins via load 14 / +1.
        do_reset("reset1");
        apply(2'd0, 4'd0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            apply(2'd0, 4'd14, 1'b1);
            check($sformatf("win_load%0d", k), model_vec());
            apply(2'd0, 4'd0, 1'b0);
            check($sformatf("win_step%0d", k), model_vec());
        end
        apply(2'd0, 4'd14, 1'b1);
        check("win15_pulse", pack(14, 0, 1, 0, 14, 0, 0, 0));
        apply(2'd0, 4'd14, 1'b1);
        check("win15_tally", pack(14, 0, 0, 0, 15, 0, 0, 0));
        apply(2'd0, 4'd14, 1'b1);
        check("gameover", pack(14, 0, 0, 0, 15, 0, 1, 1));
        apply(2'd0, 4'd0, 1'b0);
`ifdef MODPORT_GAME_AUTOCLR_EN
        check("autoclear", 21'd0);
        apply(2'd0, 4'd0, 1'b0);
        check("restart_step", pack(1, 1, 0, 0, 0, 0, 0, 0));
`else
        check("gameover_hold1", pack(14, 0, 0, 0, 15, 0, 1, 1));
        apply(2'd0, 4'd5, 1'b1);
        check("gameover_load_ignored", pack(14, 0, 0, 0, 15, 0, 1, 1));
`endif
        check("gameover_model", model_vec());

        // Random play against the model.
        do_reset("reset2");
        for (int n = 0; n < 600; n++) begin
            logic [1:0] c;
            logic [3:0] il;
            logic       ic;
            c  = 2'($urandom_range(0, 3));
            il = 4'($urandom_range(0, 15));
            ic = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) do_reset($sformatf("rand_reset%0d", n));
            apply(c, il, ic);
            check($sformatf("rand%0d", n), model_vec());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
